count_pwm_sampler: RTL and testbench
====================================

// Module: count_pwm_sampler
// PURPOSE
//   Downstream consumer of the 3-bit asynchronous ripple counter. Brings the
//   ripple count into a fast clk domain and filters out ripple transients.
//   Tracks and validates the count sequence, and flags wrap, restart and skip events.
//   Generates a PWM output by comparing the filtered count against a
//   double-buffered duty value.
// PARAMETERS
//   W       3  width of the counter input and of the duty value
//   STABLE  2  consecutive equal synced samples required to accept a value (>=1)
//   WRAP_W  8  width of the wrap-event counter
// PORTS
//   clk         in   1       sampling clock; >= (STABLE+3)x faster than the counter's clk
//   res         in   1       async active-high reset
//   cnt_in      in   W       raw ripple-counter output (asynchronous to clk)
//   duty        in   W       requested PWM duty in counts (0 = always low)
//   duty_load   in   1       1-cycle strobe: capture duty into the shadow register
//   cnt_q       out  W       filtered, accepted count
//   cnt_valid   out  1       1 once the first value has been accepted
//   pwm_out     out  1       cnt_valid && (cnt_q < duty_act)
//   wrap_pulse  out  1       1-cycle pulse on accepted transition (2^W-1) -> 0
//   restart     out  1       1-cycle pulse on accepted transition to 0 from a value other than 2^W-1 (upstream reset)
//   err_skip    out  1       1-cycle pulse on accepted nonzero value that is not cnt_q+1
//   wrap_cnt    out  WRAP_W  number of wrap_pulse events, modulo 2^WRAP_W
// BEHAVIOUR
//   Reset (async, res=1): s1, s2, stab, cnt_q, duty_shd and duty_act = 0;
//     cnt_valid = 0; all pulses = 0; wrap_cnt = 0; FSM = INIT.
//   Sync: s1 <= cnt_in, then s2 <= s1 (2-flop). stab counts cycles with s2 == prev s2,
//     saturates at STABLE, and is reloaded to 1 when s2 changes.
//   Accept event: stab == STABLE and (s2 != cnt_q or FSM == INIT).
//     Latency: cnt_in settles before edge 0 -> cnt_q updates at edge 1+STABLE
//     (edge 3 by default). Ripple transients shorter than STABLE cycles are never accepted.
//   FSM INIT: on accept -> cnt_q <= s2, cnt_valid <= 1, FSM -> TRACK. Raise no pulse.
//   FSM TRACK: on accept, classify the new value n against the old value o = cnt_q:
//     n == o+1 (mod 2^W), n != 0   : normal; raise no pulse
//     n == 0, o == 2^W-1            : wrap_pulse; wrap_cnt += 1 (wraps to 0)
//     n == 0, o != 2^W-1            : restart
//     any other n                   : err_skip
//     In every case cnt_q <= n. Pulses are registered and coincide with the
//     cycle in which cnt_q first shows n.
//   Duty: duty_load -> duty_shd <= duty. On the cycle wrap_pulse or restart is
//     asserted, duty_act <= duty_shd. If duty_load coincides with that cycle,
//     duty_act takes the incoming duty directly and duty_shd also gets it.
//   PWM: registered from the next-state values, so it is aligned with cnt_q.
//     duty_act = 0 -> always low. With W=3, duty_act = 7 -> low only when cnt_q = 7.
//   Reset mid-operation: all state is cleared immediately. After release the
//     first accepted value re-enters TRACK from INIT without a pulse.
// TESTING
//   1. Reset, then cnt_in cycles 0..7,0 with 8 clk per value -> cnt_valid after
//      3 clk; cnt_q follows each value 3 clk later; 1 wrap_pulse; wrap_cnt = 1.
//   2. cnt_in 3 -> 2 -> 4, with the glitch value 2 held 1 clk -> 2 is never accepted;
//      cnt_q goes 3 -> 4 with no err_skip.
//   3. duty_load with duty=5 mid-period -> PWM is unchanged until the next wrap; then it is
//      high for cnt_q 0..4 and low for 5..7. duty=0 -> pwm_out is stuck at 0.
//   4. cnt_q=4, then cnt_in forced to 0 (upstream reset) -> restart=1 for 1 clk;
//      no wrap_pulse; wrap_cnt unchanged; shadow duty applied.
//   5. cnt_q=2, then cnt_in jumps to 6 -> err_skip=1 for 1 clk; cnt_q=6.
//   6. Assert res while cnt_q=5 and wrap_cnt=9 -> all outputs 0 in the same timestep;
//      after release, cnt_in=5 held -> cnt_valid=1, cnt_q=5, no pulse.

Source files
------------

// File: rtl/count_pwm_sampler.sv
// ---------------------------------------------------------------------------
// count_pwm_sampler
//   Consumer of a free-running 3-bit ripple counter that runs on its own,
//   slower clock. The raw count is brought into the clk domain through a
//   2-flop synchronizer. A value is accepted only after it has been seen
//   unchanged on the synchronizer output for STABLE consecutive cycles, so
//   short ripple transients never propagate. Accepted values are checked
//   against the expected count sequence: a wrap (max -> 0), a restart
//   (anything else -> 0) and a skip (non-successor nonzero value) each raise
//   a one-cycle flag. The filtered count also drives a PWM comparator whose
//   duty value is double-buffered and only switched at a period boundary
//   (wrap or restart).
//
// Ports
//   clk         in   1       sampling clock (much faster than the counter)
//   res         in   1       asynchronous active-high reset
//   cnt_in      in   W       raw ripple-counter value, asynchronous to clk
//   duty        in   W       requested duty in counts (0 = always low)
//   duty_load   in   1       strobe: capture duty into the shadow register
//   cnt_q       out  W       filtered, accepted count
//   cnt_valid   out  1       high once the first value has been accepted
//   pwm_out     out  1       cnt_valid && (cnt_q < active duty)
//   wrap_pulse  out  1       pulse on accepted transition max -> 0
//   restart     out  1       pulse on accepted transition to 0 from non-max
//   err_skip    out  1       pulse on accepted nonzero non-successor value
//   wrap_cnt    out  WRAP_W  number of wrap pulses, modulo 2^WRAP_W
// ---------------------------------------------------------------------------
module count_pwm_sampler #(
  parameter int W      = 3,
  parameter int STABLE = 2,
  parameter int WRAP_W = 8
) (
  input  logic              clk,
  input  logic              res,
  input  logic [W-1:0]      cnt_in,
  input  logic [W-1:0]      duty,
  input  logic              duty_load,
  output logic [W-1:0]      cnt_q,
  output logic              cnt_valid,
  output logic              pwm_out,
  output logic              wrap_pulse,
  output logic              restart,
  output logic              err_skip,
  output logic [WRAP_W-1:0] wrap_cnt
);

  localparam int            SW       = $clog2(STABLE + 1);
  localparam logic [SW-1:0] STAB_MAX = SW'(STABLE);
  localparam logic [W-1:0]  CNT_MAX  = '1;

  typedef enum logic {INIT, TRACK} state_t;

  state_t        state_reg;
  logic [W-1:0]  s1_reg, s2_reg;
  logic [SW-1:0] stab_reg, stab_next;
  logic [W-1:0]  duty_shd_reg, duty_shd_next;
  logic [W-1:0]  duty_act_reg, duty_act_next;
  logic [W-1:0]  cnt_q_next;
  logic [W-1:0]  succ;
  logic          valid_next;
  logic          pwm_next;
  logic          accept;
  logic          is_wrap, is_restart, is_skip;

  always_comb begin
    // stab is the number of consecutive cycles s2 has held its current
    // value. s1 is the value s2 is about to take, so a mismatch between the
    // two means s2 changes on this edge and the run restarts at 1.
    stab_next = '0;
    if (s1_reg != s2_reg)
      stab_next = SW'(1);
    else if (stab_reg == STAB_MAX)
      stab_next = STAB_MAX;
    else
      stab_next = stab_reg + 1'b1;

    // In INIT the first stable value is taken even if it equals the reset
    // value of cnt_q; afterwards only real changes are accepted.
    accept = (stab_reg == STAB_MAX) &&
             ((s2_reg != cnt_q) || (state_reg == INIT));

    succ       = cnt_q + 1'b1;
    is_wrap    = 1'b0;
    is_restart = 1'b0;
    is_skip    = 1'b0;
    if (accept && (state_reg == TRACK)) begin
      if (s2_reg == '0) begin
        is_wrap    = (cnt_q == CNT_MAX);
        is_restart = (cnt_q != CNT_MAX);
      end else begin
        is_skip    = (s2_reg != succ);
      end
    end

    cnt_q_next = accept ? s2_reg : cnt_q;
    valid_next = cnt_valid | accept;

    // A load coinciding with a period boundary goes straight through to the
    // active duty, because the boundary copies the already-updated shadow.
    duty_shd_next = duty_load ? duty : duty_shd_reg;
    duty_act_next = (is_wrap || is_restart) ? duty_shd_next : duty_act_reg;

    // Computed from next-state values so pwm_out lines up with cnt_q.
    pwm_next = valid_next && (cnt_q_next < duty_act_next);
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_reg    <= INIT;
      s1_reg       <= '0;
      s2_reg       <= '0;
      stab_reg     <= '0;
      duty_shd_reg <= '0;
      duty_act_reg <= '0;
      cnt_q        <= '0;
      cnt_valid    <= 1'b0;
      pwm_out      <= 1'b0;
      wrap_pulse   <= 1'b0;
      restart      <= 1'b0;
      err_skip     <= 1'b0;
      wrap_cnt     <= '0;
    end else begin
      s1_reg       <= cnt_in;
      s2_reg       <= s1_reg;
      stab_reg     <= stab_next;
      duty_shd_reg <= duty_shd_next;
      duty_act_reg <= duty_act_next;
      cnt_q        <= cnt_q_next;
      cnt_valid    <= valid_next;
      pwm_out      <= pwm_next;
      wrap_pulse   <= is_wrap;
      restart      <= is_restart;
      err_skip     <= is_skip;
      if (is_wrap)
        wrap_cnt <= wrap_cnt + 1'b1;
      if (accept)
        state_reg <= TRACK;
    end
  end

endmodule

// File: tb/tb_count_pwm_sampler.sv
// ---------------------------------------------------------------------------
// tb_count_pwm_sampler
//   Drives directed and random ripple-count sequences into count_pwm_sampler.
//   For every clock edge a reference model pushes the expected output set
//   into a queue; a monitor on the falling edge pops and compares.
//   The model works on the list of values sampled by the synchronizer:
//   a value is accepted once it has been the synchronizer output for STABLE
//   consecutive samples, and accepted values are then classified by the
//   counting rules.
// ---------------------------------------------------------------------------
module tb_count_pwm_sampler;

  localparam int W      = 3;
  localparam int STABLE = 2;
  localparam int WRAP_W = 8;
  localparam int MAXV   = (1 << W) - 1;

  logic              clk = 1'b0;
  logic              res = 1'b1;
  logic [W-1:0]      cnt_in = '0;
  logic [W-1:0]      duty = '0;
  logic              duty_load = 1'b0;
  logic [W-1:0]      cnt_q;
  logic              cnt_valid, pwm_out, wrap_pulse, restart, err_skip;
  logic [WRAP_W-1:0] wrap_cnt;

  count_pwm_sampler #(.W(W), .STABLE(STABLE), .WRAP_W(WRAP_W)) dut (
    .clk(clk), .res(res), .cnt_in(cnt_in), .duty(duty), .duty_load(duty_load),
    .cnt_q(cnt_q), .cnt_valid(cnt_valid), .pwm_out(pwm_out),
    .wrap_pulse(wrap_pulse), .restart(restart), .err_skip(err_skip),
    .wrap_cnt(wrap_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int q; bit valid; bit pwm; bit wrap; bit rst; bit skip; int wcnt; bit acc;
  } exp_t;

  exp_t expq[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state
  int hist[$];   // synchronizer samples, oldest first; last = newest in flight
  int m_q, m_wcnt, m_shd, m_act;
  bit m_valid;
  int cur;       // value currently presented on cnt_in

  task automatic model_reset();
    hist.delete();
    hist.push_back(0);   // first sync stage holds 0 out of reset
    m_q = 0; m_valid = 0; m_wcnt = 0; m_shd = 0; m_act = 0;
  endtask

  task automatic model_edge();
    exp_t e;
    int   n, v;
    bit   acc;
    acc = 0; v = 0;
    e.wrap = 0; e.rst = 0; e.skip = 0;
    n = hist.size();
    // Newest sample is still in flight; the STABLE before it must agree.
    if (n - 1 >= STABLE) begin
      v   = hist[n-2];
      acc = 1;
      for (int i = n - 1 - STABLE; i <= n - 2; i++)
        if (hist[i] != v) acc = 0;
      if (acc && m_valid && v == m_q) acc = 0;
    end
    if (duty_load) m_shd = int'(duty);
    if (acc) begin
      if (m_valid) begin
        if (v == 0 && m_q == MAXV) begin
          e.wrap = 1; m_wcnt = (m_wcnt + 1) % (1 << WRAP_W);
        end else if (v == 0) begin
          e.rst = 1;
        end else if (v != (m_q + 1) % (MAXV + 1)) begin
          e.skip = 1;
        end
      end
      m_q = v; m_valid = 1;
    end
    if (e.wrap || e.rst) m_act = m_shd;
    hist.push_back(int'(cnt_in));
    if (hist.size() > STABLE + 1) void'(hist.pop_front());
    e.q = m_q; e.valid = m_valid; e.wcnt = m_wcnt; e.acc = acc;
    e.pwm = m_valid && (m_q < m_act);
    expq.push_back(e);
  endtask

  // Monitor: one comparison per expected entry.
  always @(negedge clk) begin
    exp_t e;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      checks++;
      if (int'(cnt_q) != e.q || cnt_valid != e.valid || pwm_out != e.pwm ||
          wrap_pulse != e.wrap || restart != e.rst || err_skip != e.skip ||
          int'(wrap_cnt) != e.wcnt) begin
        errors++;
        $display("FAIL outputs t=%0t: got q=%0d v=%0b pwm=%0b wrap=%0b rst=%0b skip=%0b wcnt=%0d, want q=%0d v=%0b pwm=%0b wrap=%0b rst=%0b skip=%0b wcnt=%0d",
                 $time, cnt_q, cnt_valid, pwm_out, wrap_pulse, restart, err_skip, wrap_cnt,
                 e.q, e.valid, e.pwm, e.wrap, e.rst, e.skip, e.wcnt);
      end else if (e.acc) begin
        $display("txn t=%0t cnt_q=%0d pwm=%0b wrap=%0b rst=%0b skip=%0b wcnt=%0d",
                 $time, cnt_q, pwm_out, wrap_pulse, restart, err_skip, wrap_cnt);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  function automatic int out_vec();
    return int'({cnt_q, cnt_valid, pwm_out, wrap_pulse, restart, err_skip, wrap_cnt});
  endfunction

  task automatic step(input int c, input bit ld, input int d);
    @(negedge clk);
    cnt_in = W'(c); duty_load = ld; duty = W'(d); cur = c;
    @(posedge clk);
    model_edge();
  endtask

  task automatic hold(input int c, input int n);
    for (int i = 0; i < n; i++) step(c, 1'b0, 0);
  endtask

  task automatic release_step(input int c);
    @(negedge clk);
    res = 1'b0; cnt_in = W'(c); duty_load = 1'b0; cur = c;
    @(posedge clk);
    model_edge();
  endtask

  initial begin
    int guard, nv, r;
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset_outputs", out_vec(), 0);

    // 1: clean count 0..7,0
    release_step(0);
    hold(0, 7);
    for (int v = 1; v <= MAXV + 1; v++) hold(v % (MAXV + 1), 8);
    @(negedge clk);
    chk("wrap_cnt_after_cycle", int'(wrap_cnt), 1);

    // 2: glitch 3 -> 2(1 clk) -> 4
    for (int v = 1; v <= 3; v++) hold(v, 8);
    hold(2, 1);
    hold(4, 8);
    chk("glitch_cnt_q", int'(cnt_q), 4);

    // 3: duty 5 loaded mid-period, applied at next wrap; then duty 0
    step(5, 1'b1, 5); hold(5, 7);
    for (int v = 6; v <= MAXV + 1 + MAXV; v++) hold(v % (MAXV + 1), 8);
    step(0, 1'b1, 0); hold(0, 7);
    for (int v = 1; v <= MAXV; v++) hold(v, 8);

    // 4: restart from 4
    hold(0, 8);
    for (int v = 1; v <= 4; v++) hold(v, 8);
    step(4, 1'b1, 3); hold(4, 3);
    hold(0, 8);

    // 5: skip 2 -> 6
    hold(1, 8); hold(2, 8); hold(6, 8);

    // 6: count to wrap_cnt = 9, cnt_q = 5, then reset
    guard = 0;
    while (!(m_wcnt == 9 && m_q == 5) && guard < 200) begin
      hold((cur + 1) % (MAXV + 1), 6);
      guard++;
    end
    chk("reach_wcnt9_q5", int'(wrap_cnt) * 16 + int'(cnt_q), 9 * 16 + 5);
    @(negedge clk);
    #1 res = 1'b1;
    #1 chk("async_reset_outputs", out_vec(), 0);
    model_reset();
    repeat (2) @(negedge clk);
    release_step(5);
    hold(5, 7);
    chk("post_reset_q_valid", int'(cnt_q) * 2 + int'(cnt_valid), 5 * 2 + 1);

    // Random phase
    for (int it = 0; it < 300; it++) begin
      r = $urandom_range(0, 99);
      if (r < 70)      nv = (cur + 1) % (MAXV + 1);
      else if (r < 78) nv = 0;
      else if (r < 88) nv = $urandom_range(0, MAXV);
      else begin
        step($urandom_range(0, MAXV), 1'b0, 0);  // 1-clk ripple transient
        nv = (cur + 1) % (MAXV + 1);
      end
      step(nv, ($urandom_range(0, 7) == 0), $urandom_range(0, MAXV));
      hold(nv, $urandom_range(4, 8));
    end

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
